icache_direct_mapped: RTL and testbench

- Direct-mapped, read-only instruction cache between the CPU fetch port (PC) and a block-wide instruction memory.
- Replaces the combinational `INSTRUCTION = instr_mem[PC..PC+3]` fetch path.
- Returns a 32-bit instruction on hit with no stall.
- On miss, stalls the CPU via BUSYWAIT while it fetches a 16-byte block.

---
 rtl/icache_direct_mapped_pkg.sv | 17 +
 rtl/icache_line_array.sv | 30 +++
 rtl/icache_direct_mapped.sv | 51 +++++
 tb/tb_icache_direct_mapped.sv | 118 +++++++++++
 4 files changed

// File: rtl/icache_direct_mapped_pkg.sv
// icache_direct_mapped_pkg: shared FSM encodings, address field positions and line types for the instruction cache
package icache_direct_mapped_pkg;
  localparam int NUM_BLOCKS = 8;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int ADDR_W = 10;
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = ADDR_W - 7;
  localparam int BLOCK_W = 128;
  localparam int TAG_HI = 9;
  localparam int TAG_LO = 7;
  localparam int IDX_HI = 6;
  localparam int IDX_LO = 4;
  localparam int WORD_HI = 3;
  localparam int WORD_LO = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, MEM_READ = 2'd1, UPDATE = 2'd2} state_t;
  typedef logic [WORDS_PER_BLOCK-1:0][31:0] line_t;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: data/tag/valid storage; clk, clr clears valid, we writes line/tag at wr_idx, rd_* combinational at rd_idx
module icache_line_array
  import icache_direct_mapped_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  line_t            wr_line,
  output line_t            rd_line,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid
);
  line_t            data [NUM_BLOCKS];
  logic [TAG_W-1:0] tags [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid;
  always_ff @(posedge clk) begin
    if (clr) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
    if (we) begin
      data[wr_idx] <= wr_line;
      tags[wr_idx] <= wr_tag;
    end
  end
  assign rd_line = data[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_valid = valid[rd_idx];
endmodule

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped I-cache; ADDRESS in, READDATA/BUSYWAIT to CPU, mem_read/mem_address/mem_readdata/mem_busywait block fill port
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [ADDR_W-1:0]  ADDRESS,
  output logic [31:0]        READDATA,
  output logic               BUSYWAIT,
  output logic               mem_read,
  output logic [5:0]         mem_address,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);
  state_t state, next;
  logic [5:0] fill_addr;
  line_t fill_data, rd_line;
  logic [TAG_W-1:0] rd_tag;
  logic rd_valid, hit, unused;
  assign unused = ^ADDRESS[1:0];
  icache_line_array u_lines (
    .clk(CLK),
    .clr(RESET),
    .rd_idx(ADDRESS[IDX_HI:IDX_LO]),
    .we(state == UPDATE && !RESET),
    .wr_idx(fill_addr[IDX_W-1:0]),
    .wr_tag(fill_addr[5:IDX_W]),
    .wr_line(fill_data),
    .rd_line(rd_line),
    .rd_tag(rd_tag),
    .rd_valid(rd_valid)
  );
  assign hit = rd_valid && rd_tag == ADDRESS[TAG_HI:TAG_LO];
  assign READDATA = rd_line[ADDRESS[WORD_HI:WORD_LO]];
  always_comb begin
    next = state == IDLE ? (hit ? IDLE : MEM_READ) : state == MEM_READ ? (mem_busywait ? MEM_READ : UPDATE) : IDLE;
    BUSYWAIT = !RESET && (state != IDLE || !hit);
    mem_read = !RESET && state == MEM_READ;
    mem_address = mem_read ? fill_addr : 6'd0;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      fill_addr <= '0;
    end else begin
      state <= next;
      if (state == IDLE && !hit) fill_addr <= ADDRESS[TAG_HI:IDX_LO];
    end
    if (state == MEM_READ && !mem_busywait) fill_data <= mem_readdata;
  end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: directed self-checking bench with a latency-programmable block memory model
module tb_icache_direct_mapped;
  logic CLK = 0, RESET = 1;
  logic [9:0] ADDRESS = '0;
  logic [31:0] READDATA;
  logic BUSYWAIT, mem_read, mem_busywait;
  logic [5:0] mem_address;
  logic [127:0] mem_readdata;
  int lat = 5, cnt = 0, n_cmp = 0, n_bad = 0;
  int busy, rd;
  logic [5:0] ma;
  logic [31:0] rdata;
  icache_direct_mapped dut (
    .CLK(CLK), .RESET(RESET), .ADDRESS(ADDRESS), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .mem_read(mem_read), .mem_address(mem_address), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );
  always #5 CLK = ~CLK;
  function automatic logic [31:0] word_of(logic [5:0] b, int w);
    return w * 32'h11111111 + {2'b00, b, 24'h0};
  endfunction
  always @(posedge CLK) cnt <= mem_read ? cnt + 1 : 0;
  assign mem_busywait = mem_read && (cnt < lat - 1);
  assign mem_readdata = {word_of(mem_address, 3), word_of(mem_address, 2), word_of(mem_address, 1), word_of(mem_address, 0)};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic miss_run(input logic [9:0] a, output int b, output int r, output logic [5:0] m, output logic [31:0] d);
    b = 0; r = 0; m = 'x;
    ADDRESS = a;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      b++;
      if (mem_read) begin
        r++;
        m = mem_address;
      end
    end
    d = READDATA;
    @(posedge CLK); #1;
  endtask
  task automatic hit_chk(input logic [9:0] a, input logic [31:0] exp);
    ADDRESS = a;
    @(negedge CLK);
    check("hit_busy", 32'(BUSYWAIT), 0);
    check("hit_mem_read", 32'(mem_read), 0);
    check("hit_data", READDATA, exp);
    @(posedge CLK); #1;
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", 32'(BUSYWAIT), 0);
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_mem_addr", 32'(mem_address), 0);
    @(posedge CLK); #1;
    RESET = 0;
    miss_run(10'h000, busy, rd, ma, rdata);
    check("cold_busy", busy, 7);
    check("cold_rd", rd, 5);
    check("cold_addr", 32'(ma), 32'h00);
    check("cold_data", rdata, 32'h00000000);
    hit_chk(10'h004, 32'h11111111);
    hit_chk(10'h008, 32'h22222222);
    hit_chk(10'h00C, 32'h33333333);
    miss_run(10'h010, busy, rd, ma, rdata);
    check("c1_addr", 32'(ma), 32'h01);
    check("c1_data", rdata, word_of(6'h01, 0));
    miss_run(10'h090, busy, rd, ma, rdata);
    check("c2_busy", busy, 7);
    check("c2_addr", 32'(ma), 32'h09);
    check("c2_data", rdata, word_of(6'h09, 0));
    miss_run(10'h010, busy, rd, ma, rdata);
    check("c3_busy", busy, 7);
    check("c3_addr", 32'(ma), 32'h01);
    check("c3_data", rdata, word_of(6'h01, 0));
    lat = 1;
    miss_run(10'h3F0, busy, rd, ma, rdata);
    check("fast_busy", busy, 3);
    check("fast_rd", rd, 1);
    check("fast_addr", 32'(ma), 32'h3F);
    check("fast_data", rdata, word_of(6'h3F, 0));
    hit_chk(10'h3FC, word_of(6'h3F, 3));
    lat = 5;
    ADDRESS = 10'h020;
    repeat (4) @(negedge CLK);
    check("mid_mem_read", 32'(mem_read), 1);
    check("mid_mem_addr", 32'(mem_address), 32'h02);
    RESET = 1;
    @(posedge CLK); #1;
    RESET = 0;
    @(negedge CLK);
    check("mid_drop_read", 32'(mem_read), 0);
    check("mid_valid2", 32'(dut.u_lines.valid[2]), 0);
    check("mid_valid0", 32'(dut.u_lines.valid[0]), 0);
    @(posedge CLK); #1;
    RESET = 1;
    @(posedge CLK); #1;
    RESET = 0;
    miss_run(10'h020, busy, rd, ma, rdata);
    check("re_busy", busy, 7);
    check("re_addr", 32'(ma), 32'h02);
    check("re_data", rdata, word_of(6'h02, 0));
    lat = 2;
    for (int i = 0; i < 8; i++) begin
      miss_run(10'((i << 7) | (i << 4)), busy, rd, ma, rdata);
      check("fill_busy", busy, 4);
      check("fill_addr", 32'(ma), 32'(i * 9));
    end
    for (int i = 0; i < 8; i++) hit_chk(10'((i << 7) | (i << 4) | 4), word_of(6'(i * 9), 1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
